tx_router2mac: RTL and testbench

Egress adapter from a router local output port to the 10G MAC transmit interface. It is the transmit-side mirror of the MAC-to-router receive adapter.
- Accepts 70-bit flits from the router using the val/ack handshake.
- Stores whole packets in a flit FIFO (store-and-forward).
- Streams each complete packet to the MAC as back-to-back 64-bit words with a 4-bit valid field.
- Inserts a programmable idle gap after each packet.

---
 rtl/tx_router2mac_pkg.sv | 28 ++
 rtl/tx_router2mac_pkt_commit_fifo.sv | 64 ++++++
 rtl/tx_router2mac.sv | 129 ++++++++++++
 tb/tb_tx_router2mac.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_router2mac_pkg.sv
// Shared encodings for the router-to-MAC egress adapter: flit flags, flit bit
// positions and the read-side state type.
package tx_router2mac_pkg;

    localparam logic [1:0] FLG_HDR    = 2'b10;
    localparam logic [1:0] FLG_BODY   = 2'b00;
    localparam logic [1:0] FLG_TAIL   = 2'b01;
    localparam logic [1:0] FLG_SINGLE = 2'b11;

    localparam int HDR_BIT   = 69;
    localparam int TAIL_BIT  = 68;
    localparam int VALID_LSB = 0;
    localparam int VALID_W   = 4;
    localparam int PAY_LSB   = 4;
    localparam int PAY_W     = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP
    } rd_state_t;

    function automatic logic is_tail(input logic [1:0] flg);
        return (flg == FLG_TAIL) || (flg == FLG_SINGLE);
    endfunction

endpackage

// File: rtl/tx_router2mac_pkt_commit_fifo.sv
// Flit FIFO with a commit pointer: the reader only ever sees whole packets,
// and an open (uncommitted) packet can be rolled back in one cycle.
module tx_router2mac_pkt_commit_fifo #(
    parameter int DW    = 70,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_commit,
    input  logic          i_rollback,
    input  logic          i_rd_en,
    input  logic          i_pkt_done,
    output logic [DW-1:0] o_rd_data,
    output logic          o_full,
    output logic          o_open,
    output logic [AW:0]   o_pkt_cnt
);

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_wr_commit;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_pkt_cnt;
    logic [DW-1:0] r_rd_data;
    logic [AW:0]   w_wr_base;

    // A rollback and a new write on the same edge: the write lands at the commit point.
    assign w_wr_base = i_rollback ? r_wr_commit : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[w_wr_base[AW-1:0]] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_pkt_cnt   <= '0;
            r_rd_data   <= '0;
        end else begin
            r_wr_ptr <= i_wr_en ? w_wr_base + 1'b1 : w_wr_base;
            if (i_commit) r_wr_commit <= w_wr_base + 1'b1;
            if (i_rd_en) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            case ({i_commit, i_pkt_done})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
    assign o_open    = (r_wr_ptr != r_wr_commit);
    assign o_pkt_cnt = r_pkt_cnt;

endmodule

// File: rtl/tx_router2mac.sv
// Router egress to 10G MAC transmit: store-and-forward packet buffering,
// oversize/abort discard, and back-to-back word streaming with an idle gap.
module tx_router2mac
    import tx_router2mac_pkg::*;
#(
    parameter int DATA_WIDTH = 70,
    parameter int FIFO_DEPTH = 32,
    parameter int FIFO_AW    = 5,
    parameter int IFG_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_router,
    input  logic                  val,
    output logic                  ack,
    output logic [63:0]           data_mac,
    output logic [3:0]            valid_mac,
    output logic                  eop_mac,
    input  logic                  mac_ready,
    output logic                  drop_err
);

    // GAP hands straight to LOAD, so IDLE/LOAD overhead is part of the gap;
    // gaps below 2 cycles cannot be met and round up to 2.
    localparam logic [3:0] GAP_LOAD = (IFG_CYCLES > 2) ? 4'(IFG_CYCLES - 2) : 4'd0;

    rd_state_t       r_state;
    logic [3:0]      r_gap;
    logic            r_drop;
    logic            r_drop_err;
    logic [63:0]     r_data_mac;
    logic [3:0]      r_valid_mac;
    logic            r_eop_mac;

    logic                  w_full;
    logic                  w_open;
    logic [FIFO_AW:0]      w_pkt_cnt;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_accept;
    logic                  w_in_tail;
    logic                  w_guard;
    logic                  w_abort;
    logic                  w_wr_en;
    logic                  w_rd_tail;
    logic                  w_rd_en;
    logic                  w_pkt_done;
    logic                  w_unused_hdr;

    assign ack        = rst && (r_drop || !w_full);
    assign w_accept   = val && ack;
    assign w_in_tail  = is_tail(data_router[HDR_BIT:TAIL_BIT]);
    assign w_guard    = w_full && (w_pkt_cnt == '0) && !r_drop;
    assign w_abort    = w_accept && !r_drop && (data_router[HDR_BIT:TAIL_BIT] == FLG_HDR) && w_open;
    assign w_wr_en    = w_accept && !r_drop;
    assign w_rd_tail  = w_rd_data[TAIL_BIT];
    assign w_rd_en    = (r_state == S_LOAD) || ((r_state == S_SEND) && !w_rd_tail);
    assign w_pkt_done = (r_state == S_SEND) && w_rd_tail;
    assign w_unused_hdr = w_rd_data[HDR_BIT];

    tx_router2mac_pkt_commit_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (data_router),
        .i_commit   (w_wr_en && w_in_tail),
        .i_rollback (w_guard || w_abort),
        .i_rd_en    (w_rd_en),
        .i_pkt_done (w_pkt_done),
        .o_rd_data  (w_rd_data),
        .o_full     (w_full),
        .o_open     (w_open),
        .o_pkt_cnt  (w_pkt_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_gap       <= '0;
            r_drop      <= 1'b0;
            r_drop_err  <= 1'b0;
            r_data_mac  <= '0;
            r_valid_mac <= '0;
            r_eop_mac   <= 1'b0;
        end else begin
            r_drop_err <= w_guard || w_abort;
            if (w_guard) r_drop <= 1'b1;
            else if (r_drop && w_accept && w_in_tail) r_drop <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_data_mac  <= '0;
                    r_valid_mac <= '0;
                    r_eop_mac   <= 1'b0;
                    if (w_pkt_cnt != '0 && mac_ready) r_state <= S_LOAD;
                end
                S_LOAD: r_state <= S_SEND;
                S_SEND: begin
                    r_data_mac  <= w_rd_data[PAY_LSB +: PAY_W];
                    r_valid_mac <= w_rd_data[VALID_LSB +: VALID_W];
                    r_eop_mac   <= w_rd_tail;
                    if (w_rd_tail) begin
                        r_state <= S_GAP;
                        r_gap   <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    r_data_mac  <= '0;
                    r_valid_mac <= '0;
                    r_eop_mac   <= 1'b0;
                    if (r_gap == 4'd0)
                        r_state <= (w_pkt_cnt != '0 && mac_ready) ? S_LOAD : S_IDLE;
                    else
                        r_gap <= r_gap - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_mac  = r_data_mac;
    assign valid_mac = r_valid_mac;
    assign eop_mac   = r_eop_mac;
    assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_tx_router2mac.sv
// Directed bench for tx_router2mac: a negedge monitor logs MAC words with
// edge stamps, the main sequence drives packets and checks the log.
module tb_tx_router2mac;
    import tx_router2mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [69:0] data_router;
    logic        val;
    logic        ack;
    logic [63:0] data_mac;
    logic [3:0]  valid_mac;
    logic        eop_mac;
    logic        mac_ready;
    logic        drop_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int drop_cnt = 0;

    logic [63:0] q_data[$];
    logic [3:0]  q_valid[$];
    logic        q_eop[$];
    int          q_cyc[$];

    tx_router2mac dut (
        .clk         (clk),
        .rst         (rst),
        .data_router (data_router),
        .val         (val),
        .ack         (ack),
        .data_mac    (data_mac),
        .valid_mac   (valid_mac),
        .eop_mac     (eop_mac),
        .mac_ready   (mac_ready),
        .drop_err    (drop_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_mac !== 4'b0000) begin
            q_data.push_back(data_mac);
            q_valid.push_back(valid_mac);
            q_eop.push_back(eop_mac);
            q_cyc.push_back(cyc);
        end
        if (drop_err === 1'b1) drop_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        q_data.delete();
        q_valid.delete();
        q_eop.delete();
        q_cyc.delete();
        drop_cnt = 0;
    endtask

    // Drives one flit and returns the edge count at which it was accepted.
    task automatic send_flit(input logic [1:0] flg, input logic [63:0] pay,
                             input logic [3:0] vc, output int t_acc);
        int w;
        w = 0;
        data_router = {flg, pay, vc};
        val = 1'b1;
        while (ack !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        assert (w < 200) else begin
            n_err++;
            $error("FAIL ack_wait: observed %0d cycles expected <200", w);
        end
        @(negedge clk);
        t_acc = cyc;
    endtask

    task automatic end_pkt();
        val = 1'b0;
        data_router = '0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int w;
        w = 0;
        while (q_data.size() < n && w < 300) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        assert (w < 300) else begin
            n_err++;
            $error("FAIL %s_timeout: observed %0d words expected %0d", tag, q_data.size(), n);
        end
        repeat (8) @(negedge clk);
        chk({tag, "_count"}, 64'(q_data.size()), 64'(n));
    endtask

    task automatic chk_word(input string tag, input int i, input logic [63:0] pay,
                            input logic [3:0] vc, input logic eop, input int t_exp);
        chk({tag, "_present"}, 64'(q_data.size() > i), 64'd1);
        if (q_data.size() > i) begin
            chk({tag, "_data"}, q_data[i], pay);
            chk({tag, "_valid"}, 64'(q_valid[i]), 64'(vc));
            chk({tag, "_eop"}, 64'(q_eop[i]), 64'(eop));
            chk({tag, "_cycle"}, 64'(q_cyc[i]), 64'(t_exp));
        end
    endtask

    initial begin
        int t;
        int t2;
        int c0;

        rst = 1'b0;
        val = 1'b0;
        data_router = '0;
        mac_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_valid", 64'(valid_mac), 64'd0);
        chk("rst_data", data_mac, 64'd0);
        chk("rst_eop", 64'(eop_mac), 64'd0);
        chk("rst_drop", 64'(drop_err), 64'd0);
        rst = 1'b1;
        #1;
        chk("ack_after_rst", 64'(ack), 64'd1);
        @(negedge clk);

        // 1: single 4-flit packet
        mac_ready = 1'b1;
        clr_log();
        send_flit(FLG_HDR,  64'hA000_0000_0000_0001, 4'hF, t);
        send_flit(FLG_BODY, 64'hA000_0000_0000_0002, 4'hF, t);
        send_flit(FLG_BODY, 64'hA000_0000_0000_0003, 4'hF, t);
        send_flit(FLG_TAIL, 64'hA000_0000_0000_0004, 4'h3, t);
        end_pkt();
        wait_words("p1", 4);
        chk_word("p1w0", 0, 64'hA000_0000_0000_0001, 4'hF, 1'b0, t + 3);
        chk_word("p1w1", 1, 64'hA000_0000_0000_0002, 4'hF, 1'b0, t + 4);
        chk_word("p1w2", 2, 64'hA000_0000_0000_0003, 4'hF, 1'b0, t + 5);
        chk_word("p1w3", 3, 64'hA000_0000_0000_0004, 4'h3, 1'b1, t + 6);

        // 2: two 3-flit packets written back to back
        clr_log();
        send_flit(FLG_HDR,  64'hB000_0000_0000_0001, 4'hF, t);
        send_flit(FLG_BODY, 64'hB000_0000_0000_0002, 4'hF, t);
        send_flit(FLG_TAIL, 64'hB000_0000_0000_0003, 4'h7, t);
        send_flit(FLG_HDR,  64'hC000_0000_0000_0001, 4'hF, t2);
        send_flit(FLG_BODY, 64'hC000_0000_0000_0002, 4'hF, t2);
        send_flit(FLG_TAIL, 64'hC000_0000_0000_0003, 4'h1, t2);
        end_pkt();
        wait_words("p2", 6);
        chk_word("p2b0", 0, 64'hB000_0000_0000_0001, 4'hF, 1'b0, t + 3);
        chk_word("p2b1", 1, 64'hB000_0000_0000_0002, 4'hF, 1'b0, t + 4);
        chk_word("p2b2", 2, 64'hB000_0000_0000_0003, 4'h7, 1'b1, t + 5);
        chk_word("p2c0", 3, 64'hC000_0000_0000_0001, 4'hF, 1'b0, t + 9);
        chk_word("p2c1", 4, 64'hC000_0000_0000_0002, 4'hF, 1'b0, t + 10);
        chk_word("p2c2", 5, 64'hC000_0000_0000_0003, 4'h1, 1'b1, t + 11);

        // 3: mac_ready held low with a packet buffered
        mac_ready = 1'b0;
        clr_log();
        send_flit(FLG_HDR,  64'hD000_0000_0000_0001, 4'hF, t);
        send_flit(FLG_TAIL, 64'hD000_0000_0000_0002, 4'h5, t);
        end_pkt();
        repeat (20) @(negedge clk);
        chk("p3_held", 64'(q_data.size()), 64'd0);
        mac_ready = 1'b1;
        c0 = cyc;
        wait_words("p3", 2);
        chk_word("p3w0", 0, 64'hD000_0000_0000_0001, 4'hF, 1'b0, c0 + 3);
        chk_word("p3w1", 1, 64'hD000_0000_0000_0002, 4'h5, 1'b1, c0 + 4);

        // 4: 40-flit oversize packet, then a normal 2-flit packet
        clr_log();
        for (int i = 0; i < 40; i++) begin
            send_flit((i == 0) ? FLG_HDR : ((i == 39) ? FLG_TAIL : FLG_BODY),
                      64'hE0E0_0000_0000_0000 | 64'(i), 4'hF, t);
        end
        end_pkt();
        repeat (10) @(negedge clk);
        chk("p4_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("p4_no_output", 64'(q_data.size()), 64'd0);
        send_flit(FLG_HDR,  64'hE100_0000_0000_0001, 4'hF, t);
        send_flit(FLG_TAIL, 64'hE100_0000_0000_0002, 4'h2, t);
        end_pkt();
        wait_words("p4", 2);
        chk_word("p4w0", 0, 64'hE100_0000_0000_0001, 4'hF, 1'b0, t + 3);
        chk_word("p4w1", 1, 64'hE100_0000_0000_0002, 4'h2, 1'b1, t + 4);
        chk("p4_drop_after", 64'(drop_cnt), 64'd1);

        // 5: header abort of an open packet
        clr_log();
        send_flit(FLG_HDR,  64'hF000_0000_0000_0001, 4'hF, t);
        send_flit(FLG_BODY, 64'hF000_0000_0000_0002, 4'hF, t);
        send_flit(FLG_HDR,  64'h6000_0000_0000_0001, 4'hF, t);
        send_flit(FLG_TAIL, 64'h6000_0000_0000_0002, 4'h9, t);
        end_pkt();
        wait_words("p5", 2);
        chk("p5_drop_cnt", 64'(drop_cnt), 64'd1);
        chk_word("p5w0", 0, 64'h6000_0000_0000_0001, 4'hF, 1'b0, t + 3);
        chk_word("p5w1", 1, 64'h6000_0000_0000_0002, 4'h9, 1'b1, t + 4);

        // 6: reset in the middle of sending
        clr_log();
        for (int i = 0; i < 6; i++) begin
            send_flit((i == 0) ? FLG_HDR : ((i == 5) ? FLG_TAIL : FLG_BODY),
                      64'h7000_0000_0000_0000 | 64'(i), (i == 5) ? 4'h8 : 4'hF, t);
        end
        end_pkt();
        begin
            int w;
            w = 0;
            while (q_data.size() < 1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            n_vec++;
            assert (w < 100) else begin
                n_err++;
                $error("FAIL p6_start: observed %0d words expected 1", q_data.size());
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("p6_ack_in_rst", 64'(ack), 64'd0);
        @(negedge clk);
        chk("p6_valid_in_rst", 64'(valid_mac), 64'd0);
        chk("p6_eop_in_rst", 64'(eop_mac), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        clr_log();
        repeat (10) @(negedge clk);
        chk("p6_quiet", 64'(q_data.size()), 64'd0);
        send_flit(FLG_HDR,  64'h8000_0000_0000_0001, 4'hF, t);
        send_flit(FLG_BODY, 64'h8000_0000_0000_0002, 4'hF, t);
        send_flit(FLG_TAIL, 64'h8000_0000_0000_0003, 4'h4, t);
        end_pkt();
        wait_words("p6", 3);
        chk_word("p6w0", 0, 64'h8000_0000_0000_0001, 4'hF, 1'b0, t + 3);
        chk_word("p6w1", 1, 64'h8000_0000_0000_0002, 4'hF, 1'b0, t + 4);
        chk_word("p6w2", 2, 64'h8000_0000_0000_0003, 4'h4, 1'b1, t + 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
